// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - pipeline hazard detection, forwarding select and stall/forward counters
module hazard_control_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  id_valid,
  input  logic                  fwd_en,
  input  logic                  flush,
  input  logic                  clr_cnt,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  stall,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  idex_bubble,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      fwd_cnt
);

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  // EX / MEM / WB tracking state
  logic [REG_ADDR_W-1:0] ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic                  ex_rs1_used, ex_rs2_used, ex_regwrite, ex_memread;
  logic                  mem_regwrite, mem_memread, wb_regwrite;

  logic hazard_rs1, hazard_rs2;
  logic ex_load;

  // Operand forwarding select: MEM result wins over WB; loads in MEM cannot forward yet
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (fwd_en && ex_rs1_used && ex_rs1 != REG_ZERO) begin
      if (mem_regwrite && !mem_memread && mem_rd == ex_rs1) fwd_a = 2'b10;
      else if (wb_regwrite && wb_rd == ex_rs1)              fwd_a = 2'b01;
    end
    if (fwd_en && ex_rs2_used && ex_rs2 != REG_ZERO) begin
      if (mem_regwrite && !mem_memread && mem_rd == ex_rs2) fwd_b = 2'b10;
      else if (wb_regwrite && wb_rd == ex_rs2)              fwd_b = 2'b01;
    end
  end

  // Hazard detection on ID sources: load-use only when forwarding, else any in-flight writer in EX/MEM
  always_comb begin
    hazard_rs1 = 1'b0;
    hazard_rs2 = 1'b0;
    if (id_rs1_used && id_rs1 != REG_ZERO) begin
      if (fwd_en) hazard_rs1 = ex_memread && ex_rd == id_rs1;
      else        hazard_rs1 = (ex_regwrite && ex_rd == id_rs1) || (mem_regwrite && mem_rd == id_rs1);
    end
    if (id_rs2_used && id_rs2 != REG_ZERO) begin
      if (fwd_en) hazard_rs2 = ex_memread && ex_rd == id_rs2;
      else        hazard_rs2 = (ex_regwrite && ex_rd == id_rs2) || (mem_regwrite && mem_rd == id_rs2);
    end
  end

  // Pipeline control: flush kills the ID instruction, so it overrides any stall
  always_comb begin
    stall       = id_valid && (hazard_rs1 || hazard_rs2) && !flush;
    pc_write    = !stall;
    ifid_write  = !stall;
    idex_bubble = stall || flush;
    ex_load     = id_valid && !stall && !flush;
  end

  // Advance tracking: ID enters EX only when it really issues, otherwise a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_rs1_used  <= 1'b0;
      ex_rs2_used  <= 1'b0;
      ex_regwrite  <= 1'b0;
      ex_memread   <= 1'b0;
      mem_rd       <= '0;
      mem_regwrite <= 1'b0;
      mem_memread  <= 1'b0;
      wb_rd        <= '0;
      wb_regwrite  <= 1'b0;
    end else begin
      mem_rd       <= ex_rd;
      mem_regwrite <= ex_regwrite;
      mem_memread  <= ex_memread;
      wb_rd        <= mem_rd;
      wb_regwrite  <= mem_regwrite;
      if (ex_load) begin
        ex_rs1      <= id_rs1;
        ex_rs2      <= id_rs2;
        ex_rd       <= id_rd;
        ex_rs1_used <= id_rs1_used;
        ex_rs2_used <= id_rs2_used;
        ex_regwrite <= id_regwrite;
        ex_memread  <= id_memread;
      end else begin
        ex_rs1      <= '0;
        ex_rs2      <= '0;
        ex_rd       <= '0;
        ex_rs1_used <= 1'b0;
        ex_rs2_used <= 1'b0;
        ex_regwrite <= 1'b0;
        ex_memread  <= 1'b0;
      end
    end
  end

  // Saturating performance counters; clear beats increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else if (clr_cnt) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if ((fwd_a != 2'b00 || fwd_b != 2'b00) && fwd_cnt != '1) fwd_cnt <= fwd_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - directed and random checks of hazard_control_unit against a pipeline model
module tb_hazard_control_unit;

  localparam int AW = 5;
  localparam int CW = 4;

  typedef struct packed {
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          u1;
    logic          u2;
    logic [AW-1:0] rd;
    logic          rw;
    logic          mr;
    logic          valid;
  } ins_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic          id_rs1_used, id_rs2_used, id_regwrite, id_memread, id_valid;
  logic          fwd_en, flush, clr_cnt;
  logic [1:0]    fwd_a, fwd_b;
  logic          stall, pc_write, ifid_write, idex_bubble;
  logic [CW-1:0] stall_cnt, fwd_cnt;

  hazard_control_unit #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .id_valid(id_valid),
    .fwd_en(fwd_en), .flush(flush), .clr_cnt(clr_cnt),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .pc_write(pc_write),
    .ifid_write(ifid_write), .idex_bubble(idex_bubble),
    .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB instructions in flight
  ins_t pipe [3];
  int   m_stall_cnt, m_fwd_cnt;
  ins_t cur_id;
  bit   cur_fe, cur_fl, cur_clr;
  logic [1:0] e_fwd_a, e_fwd_b;
  bit   e_stall;
  localparam int CMAX = (1 << CW) - 1;

  // last observed combinational outputs of a step
  logic [1:0] o_fwd_a, o_fwd_b;
  logic       o_stall, o_pcw, o_bub;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ins_t mk(input int rd, input int rs1, input int rs2, input bit u1, input bit u2,
                              input bit rw, input bit mr);
    ins_t i;
    i.rd = AW'(rd); i.rs1 = AW'(rs1); i.rs2 = AW'(rs2);
    i.u1 = u1; i.u2 = u2; i.rw = rw; i.mr = mr; i.valid = 1'b1;
    return i;
  endfunction

  function automatic ins_t nop();
    return '0;
  endfunction

  // youngest older writer supplies the operand; a load still in MEM has no data to give
  function automatic logic [1:0] model_fwd(input logic [AW-1:0] src, input bit used);
    if (!cur_fe || !used || src == 0) return 2'b00;
    if (pipe[1].rw && !pipe[1].mr && pipe[1].rd == src) return 2'b10;
    if (pipe[2].rw && pipe[2].rd == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit model_src_hazard(input logic [AW-1:0] s, input bit used);
    if (!used || s == 0) return 1'b0;
    if (cur_fe) return pipe[0].mr && pipe[0].rd == s;
    for (int k = 0; k < 2; k++) if (pipe[k].rw && pipe[k].rd == s) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_eval();
    e_fwd_a = model_fwd(pipe[0].rs1, pipe[0].u1);
    e_fwd_b = model_fwd(pipe[0].rs2, pipe[0].u2);
    e_stall = cur_id.valid && !cur_fl &&
              (model_src_hazard(cur_id.rs1, cur_id.u1) || model_src_hazard(cur_id.rs2, cur_id.u2));
  endtask

  task automatic model_advance();
    if (cur_clr) begin
      m_stall_cnt = 0; m_fwd_cnt = 0;
    end else begin
      if (e_stall && m_stall_cnt < CMAX) m_stall_cnt++;
      if ((e_fwd_a != 0 || e_fwd_b != 0) && m_fwd_cnt < CMAX) m_fwd_cnt++;
    end
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = (cur_id.valid && !e_stall && !cur_fl) ? cur_id : '0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) pipe[k] = '0;
    m_stall_cnt = 0; m_fwd_cnt = 0;
  endtask

  task automatic apply(input ins_t i, input bit fe, input bit fl, input bit clr);
    cur_id = i; cur_fe = fe; cur_fl = fl; cur_clr = clr;
    id_rs1 = i.rs1; id_rs2 = i.rs2; id_rs1_used = i.u1; id_rs2_used = i.u2;
    id_rd = i.rd; id_regwrite = i.rw; id_memread = i.mr; id_valid = i.valid;
    fwd_en = fe; flush = fl; clr_cnt = clr;
  endtask

  task automatic check_comb();
    model_eval();
    o_fwd_a = fwd_a; o_fwd_b = fwd_b; o_stall = stall; o_pcw = pc_write; o_bub = idex_bubble;
    check("fwd_a", 16'(fwd_a), 16'(e_fwd_a));
    check("fwd_b", 16'(fwd_b), 16'(e_fwd_b));
    check("stall", 16'(stall), 16'(e_stall));
    check("pc_write", 16'(pc_write), 16'(!e_stall));
    check("ifid_write", 16'(ifid_write), 16'(!e_stall));
    check("idex_bubble", 16'(idex_bubble), 16'(e_stall || cur_fl));
  endtask

  task automatic step(input ins_t i, input bit fe, input bit fl = 1'b0, input bit clr = 1'b0);
    apply(i, fe, fl, clr);
    #2;
    check_comb();
    @(posedge clk);
    model_advance();
    #1;
    check("stall_cnt", 16'(stall_cnt), 16'(m_stall_cnt));
    check("fwd_cnt", 16'(fwd_cnt), 16'(m_fwd_cnt));
  endtask

  task automatic check_reset_outputs(input bit fl);
    check("rst_fwd_a", 16'(fwd_a), 16'd0);
    check("rst_fwd_b", 16'(fwd_b), 16'd0);
    check("rst_stall", 16'(stall), 16'd0);
    check("rst_pc_write", 16'(pc_write), 16'd1);
    check("rst_ifid_write", 16'(ifid_write), 16'd1);
    check("rst_idex_bubble", 16'(idex_bubble), 16'(fl));
    check("rst_stall_cnt", 16'(stall_cnt), 16'd0);
    check("rst_fwd_cnt", 16'(fwd_cnt), 16'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_reset_outputs(flush);
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    apply(nop(), 1'b1, 1'b0, 1'b0);
    model_reset();
    @(posedge clk); #1;
    // reset values, with and without flush
    check_reset_outputs(1'b0);
    flush = 1'b1; #1;
    check_reset_outputs(1'b1);
    flush = 1'b0;
    rst_n = 1'b1;

    // add x5 ; sub x6,x5,x1 -> MEM forward on operand a
    step(mk(5, 2, 3, 1, 1, 1, 0), 1'b1);
    step(mk(6, 5, 1, 1, 1, 1, 0), 1'b1);
    step(nop(), 1'b1);
    check("s1_fwd_a", 16'(o_fwd_a), 16'b10);
    check("s1_stall", 16'(o_stall), 16'd0);
    check("s1_fwd_cnt", 16'(fwd_cnt), 16'd1);

    // lw x5 ; add x6,x5,x5 -> one stall, then WB forward on both operands
    do_reset();
    step(mk(5, 1, 0, 1, 0, 1, 1), 1'b1);
    step(mk(6, 5, 5, 1, 1, 1, 0), 1'b1);
    check("s2_stall", 16'(o_stall), 16'd1);
    check("s2_pc_write", 16'(o_pcw), 16'd0);
    check("s2_bubble", 16'(o_bub), 16'd1);
    step(mk(6, 5, 5, 1, 1, 1, 0), 1'b1);
    check("s2_stall_end", 16'(o_stall), 16'd0);
    step(nop(), 1'b1);
    check("s2_fwd_a", 16'(o_fwd_a), 16'b01);
    check("s2_fwd_b", 16'(o_fwd_b), 16'b01);
    check("s2_stall_cnt", 16'(stall_cnt), 16'd1);

    // stall-only: add x5 ; or x7,x5,x0 -> two stall cycles, no forwarding
    do_reset();
    step(mk(5, 1, 2, 1, 1, 1, 0), 1'b0);
    step(mk(7, 5, 0, 1, 1, 1, 0), 1'b0);
    check("s3_stall1", 16'(o_stall), 16'd1);
    step(mk(7, 5, 0, 1, 1, 1, 0), 1'b0);
    check("s3_stall2", 16'(o_stall), 16'd1);
    step(mk(7, 5, 0, 1, 1, 1, 0), 1'b0);
    check("s3_stall3", 16'(o_stall), 16'd0);
    check("s3_fwd_a", 16'(o_fwd_a), 16'd0);
    step(nop(), 1'b0);
    check("s3_stall_cnt", 16'(stall_cnt), 16'd2);

    // x0 producers never cause stalls or forwards, either mode
    for (int m = 0; m < 2; m++) begin
      do_reset();
      step(mk(0, 1, 2, 1, 1, 1, m), m[0]);
      step(mk(6, 0, 0, 1, 1, 1, 0), m[0]);
      check("s4_stall", 16'(o_stall), 16'd0);
      step(nop(), m[0]);
      check("s4_fwd_a", 16'(o_fwd_a), 16'd0);
      check("s4_fwd_b", 16'(o_fwd_b), 16'd0);
    end

    // load-use with flush: no stall, bubble, and the flushed consumer never reaches EX
    do_reset();
    step(mk(5, 1, 0, 1, 0, 1, 1), 1'b1);
    step(mk(5, 5, 0, 1, 0, 1, 1), 1'b1, 1'b1);
    check("s5_stall", 16'(o_stall), 16'd0);
    check("s5_bubble", 16'(o_bub), 16'd1);
    step(mk(8, 1, 1, 1, 1, 1, 0), 1'b1);
    step(mk(9, 5, 0, 1, 0, 1, 0), 1'b1);
    check("s5_ex_bubble", 16'(o_stall), 16'd0);

    // saturate stall_cnt via repeated stall-only RAW pairs
    do_reset();
    for (int r = 0; r < 9; r++) begin
      step(mk(5, 1, 2, 1, 1, 1, 0), 1'b0);
      step(mk(7, 5, 0, 1, 1, 1, 0), 1'b0);
      step(mk(7, 5, 0, 1, 1, 1, 0), 1'b0);
      step(mk(7, 5, 0, 1, 1, 1, 0), 1'b0);
    end
    check("s6_sat", 16'(stall_cnt), 16'(CMAX));
    step(mk(5, 1, 2, 1, 1, 1, 0), 1'b0);
    step(mk(7, 5, 0, 1, 1, 1, 0), 1'b0);
    check("s6_sat_hold", 16'(stall_cnt), 16'(CMAX));
    step(mk(7, 5, 0, 1, 1, 1, 0), 1'b0, 1'b0, 1'b1);
    check("s6_clr_stall", 16'(o_stall), 16'd1);
    check("s6_clr", 16'(stall_cnt), 16'd0);

    // reset in the middle of a load-use stall
    do_reset();
    step(mk(5, 1, 0, 1, 0, 1, 1), 1'b1);
    apply(mk(6, 5, 5, 1, 1, 1, 0), 1'b1, 1'b0, 1'b0);
    #2;
    check_comb();
    check("s7_pre_stall", 16'(stall), 16'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs(1'b0);
    model_reset();
    rst_n = 1'b1;
    step(mk(6, 5, 5, 1, 1, 1, 0), 1'b1);
    check("s7_post_stall", 16'(o_stall), 16'd0);

    // randomized traffic over a small register set to force frequent matches
    do_reset();
    begin
      bit fe;
      ins_t ri;
      fe = 1'b1;
      for (int n = 0; n < 400; n++) begin
        if ($urandom_range(0, 19) == 0) fe = ~fe;
        ri.rs1 = AW'($urandom_range(0, 3));
        ri.rs2 = AW'($urandom_range(0, 3));
        ri.rd  = AW'($urandom_range(0, 3));
        ri.u1 = 1'($urandom); ri.u2 = 1'($urandom);
        ri.rw = ($urandom_range(0, 3) != 0);
        ri.mr = ($urandom_range(0, 2) == 0);
        ri.valid = ($urandom_range(0, 7) != 0);
        step(ri, fe, ($urandom_range(0, 9) == 0), ($urandom_range(0, 39) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
